// File: rtl/eth_switch_pkg.sv
// Shared types for the TX dispatch path: FSM encoding, pointer-word field map,
// port count and the per-port readiness check.
package eth_switch_pkg;
  localparam int NPORT   = 4;
  localparam int ERR_BIT = 15;
  localparam int MAP_MSB = 14;
  localparam int MAP_LSB = 11;
  localparam int LEN_MSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RDPTR, ST_LATCH, ST_WAIT, ST_DATA, ST_PTRWR
  } state_t;

  // A frame may start only when no masked port has a full ptr FIFO or an almost-full data FIFO.
  function automatic logic ports_ready(input logic [NPORT-1:0] mask,
                                       input logic [NPORT-1:0] full,
                                       input logic [NPORT-1:0] afull);
    return ~|(mask & (full | afull));
  endfunction
endpackage

// File: rtl/tx_dispatch_ctrl_if.sv
// Shared-FIFO read side and per-port TX FIFO write side of the dispatcher.
interface tx_dispatch_ctrl_if;
  import eth_switch_pkg::*;
  logic             ptr_sfifo_empty;
  logic             ptr_sfifo_rd;
  logic [15:0]      ptr_sfifo_dout;
  logic             sfifo_rd;
  logic [7:0]       sfifo_dout;
  logic [NPORT-1:0] tx_data_fifo_wr;
  logic [7:0]       tx_data_fifo_din;
  logic [NPORT-1:0] tx_data_fifo_afull;
  logic [NPORT-1:0] tx_ptr_fifo_wr;
  logic [15:0]      tx_ptr_fifo_din;
  logic [NPORT-1:0] tx_ptr_fifo_full;

  modport master (
    input  ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, tx_data_fifo_afull, tx_ptr_fifo_full,
    output ptr_sfifo_rd, sfifo_rd, tx_data_fifo_wr, tx_data_fifo_din, tx_ptr_fifo_wr, tx_ptr_fifo_din
  );
  modport slave (
    output ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, tx_data_fifo_afull, tx_ptr_fifo_full,
    input  ptr_sfifo_rd, sfifo_rd, tx_data_fifo_wr, tx_data_fifo_din, tx_ptr_fifo_wr, tx_ptr_fifo_din
  );
endinterface

// File: rtl/tx_dispatch_stats.sv
// Delivered/dropped frame counters; instantiated only when TX_DISPATCH_STATS_EN is defined.
module tx_dispatch_stats (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc_frame,
  input  logic        inc_drop,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (inc_frame) frame_cnt <= frame_cnt + 16'd1;
      if (inc_drop)  drop_cnt  <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/tx_dispatch_ctrl.sv
// Moves one frame at a time from the shared data/pointer FIFOs to the masked TX ports.
// Optional: TX_DISPATCH_STATS_EN enables the frame/drop counters (tied to 0 otherwise).
module tx_dispatch_ctrl #(
  parameter int LEN_W = 11,
  parameter int NPORT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  tx_dispatch_ctrl_if.master  bus,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt
);
  import eth_switch_pkg::*;

  state_t           state;
  logic [NPORT-1:0] mask;
  logic [LEN_W-1:0] len, rd_left;
  logic             ptr_rd, rd, wr_vld;
  logic [NPORT-1:0] data_wr, ptr_wr;
  logic [15:0]      ptr_din;

  logic             p_err;
  logic [NPORT-1:0] p_map, p_mask;
  logic [LEN_W-1:0] p_len;

  assign p_err  = bus.ptr_sfifo_dout[ERR_BIT];
  assign p_map  = bus.ptr_sfifo_dout[MAP_MSB:MAP_LSB];
  assign p_len  = LEN_W'(bus.ptr_sfifo_dout[LEN_MSB:0]);
  // Errored or unmapped frames are drained: read out with an all-zero write mask.
  assign p_mask = p_err ? '0 : p_map;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      mask    <= '0;
      len     <= '0;
      rd_left <= '0;
      ptr_rd  <= 1'b0;
      rd      <= 1'b0;
      wr_vld  <= 1'b0;
      data_wr <= '0;
      ptr_wr  <= '0;
      ptr_din <= '0;
    end else begin
      // Every byte read lands in the TX FIFOs exactly one cycle later.
      wr_vld  <= rd;
      data_wr <= rd ? mask : '0;
      case (state)
        ST_IDLE: if (!bus.ptr_sfifo_empty) begin
          ptr_rd <= 1'b1;
          state  <= ST_RDPTR;
        end
        ST_RDPTR: begin
          ptr_rd <= 1'b0;
          state  <= ST_LATCH;
        end
        ST_LATCH: begin
          mask    <= p_mask;
          len     <= p_len;
          rd_left <= p_len - LEN_W'(1);
          if (p_len == '0) state <= ST_IDLE;
          else if (ports_ready(p_mask, bus.tx_ptr_fifo_full, bus.tx_data_fifo_afull)) begin
            rd    <= 1'b1;
            state <= ST_DATA;
          end else state <= ST_WAIT;
        end
        ST_WAIT: if (ports_ready(mask, bus.tx_ptr_fifo_full, bus.tx_data_fifo_afull)) begin
          rd    <= 1'b1;
          state <= ST_DATA;
        end
        // Backpressure is not re-sampled here: afull leaves room for a full-size frame.
        ST_DATA: if (rd) begin
          if (rd_left == '0) rd <= 1'b0;
          else               rd_left <= rd_left - LEN_W'(1);
        end else begin
          ptr_wr  <= mask;
          ptr_din <= 16'(len);
          state   <= ST_PTRWR;
        end
        ST_PTRWR: begin
          ptr_wr  <= '0;
          ptr_din <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ptr_sfifo_rd     = ptr_rd;
  assign bus.sfifo_rd         = rd;
  assign bus.tx_data_fifo_wr  = data_wr;
  assign bus.tx_data_fifo_din = wr_vld ? bus.sfifo_dout : '0;
  assign bus.tx_ptr_fifo_wr   = ptr_wr;
  assign bus.tx_ptr_fifo_din  = ptr_din;
  assign busy                 = (state != ST_IDLE);

`ifdef TX_DISPATCH_STATS_EN
  logic inc_frame, inc_drop;
  assign inc_frame = (state == ST_PTRWR) && (mask != '0);
  assign inc_drop  = ((state == ST_PTRWR) && (mask == '0)) ||
                     ((state == ST_LATCH) && (p_len == '0));

  tx_dispatch_stats u_stats (
    .clk       (clk),
    .rstn      (rstn),
    .inc_frame (inc_frame),
    .inc_drop  (inc_drop),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_tx_dispatch_ctrl.sv
// Directed bench for tx_dispatch_ctrl: FIFO models, per-write scoreboard and frame timing checks.
module tb_tx_dispatch_ctrl;
  localparam bit STATS =
`ifdef TX_DISPATCH_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tx_dispatch_ctrl_if bus();
  logic        busy;
  logic [15:0] frame_cnt, drop_cnt;

  tx_dispatch_ctrl #(.LEN_W(11), .NPORT(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Upstream FIFO models and expected-write scoreboard
  logic [15:0] ptr_q[$];
  logic [7:0]  dat_q[$];
  logic [11:0] exp_d[$];
  logic [19:0] exp_p[$];
  int exp_frame = 0, exp_drop = 0, seed = 11;
  logic [15:0] cur_ptr;

  initial begin
    bus.ptr_sfifo_dout = '0;
    bus.sfifo_dout     = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        bus.ptr_sfifo_dout <= '0;
        bus.sfifo_dout     <= '0;
      end else begin
        if (bus.ptr_sfifo_rd && ptr_q.size() > 0) bus.ptr_sfifo_dout <= ptr_q.pop_front();
        if (bus.sfifo_rd) bus.sfifo_dout <= (dat_q.size() > 0) ? dat_q.pop_front() : 8'h00;
      end
    end
  end

  initial begin
    bus.ptr_sfifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.ptr_sfifo_empty = (ptr_q.size() == 0);
    end
  end

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Frame monitor: timing marks, per-port byte counts, and write checks against the scoreboard
  int t0 = 0, t_first = -1, t_lastwr = -1, t_pw = -1, t_idle = -1, n_rd = 0, n_wr = 0;
  int port_cnt[4] = '{0, 0, 0, 0};
  bit done = 1'b0, prev_busy = 1'b0;
  logic [3:0]  last_pwr = '0;
  logic [15:0] last_pdin = '0;
  initial begin
    logic [11:0] ed;
    logic [19:0] ep;
    forever begin
      @(negedge clk);
      if (!rstn) prev_busy = 1'b0;
      else begin
        if (bus.ptr_sfifo_rd) begin
          t0 = cyc; t_first = -1; t_lastwr = -1; t_pw = -1; n_rd = 0; n_wr = 0;
        end
        if (bus.sfifo_rd) begin
          if (t_first < 0) t_first = cyc;
          n_rd++;
        end
        if (bus.tx_data_fifo_wr != '0) begin
          n_wr++; t_lastwr = cyc;
          for (int p = 0; p < 4; p++) if (bus.tx_data_fifo_wr[p]) port_cnt[p]++;
          if (exp_d.size() == 0) chk("unexpected data write", 32'(bus.tx_data_fifo_wr), 32'd0);
          else begin
            ed = exp_d.pop_front();
            chk("data wr mask", 32'(bus.tx_data_fifo_wr), 32'(ed[11:8]));
            chk("data din", 32'(bus.tx_data_fifo_din), 32'(ed[7:0]));
          end
        end
        if (bus.tx_ptr_fifo_wr != '0) begin
          t_pw = cyc; last_pwr = bus.tx_ptr_fifo_wr; last_pdin = bus.tx_ptr_fifo_din;
          if (exp_p.size() == 0) chk("unexpected ptr write", 32'(bus.tx_ptr_fifo_wr), 32'd0);
          else begin
            ep = exp_p.pop_front();
            chk("ptr wr mask", 32'(bus.tx_ptr_fifo_wr), 32'(ep[19:16]));
            chk("ptr din", 32'(bus.tx_ptr_fifo_din), 32'(ep[15:0]));
          end
        end
        if (prev_busy && !busy) begin t_idle = cyc; done = 1'b1; end
        prev_busy = busy;
      end
    end
  end

  task automatic start_frame(input logic [15:0] ptr);
    int len; bit drain; logic [3:0] map; logic [7:0] b;
    len = int'(ptr[10:0]); map = ptr[14:11]; drain = ptr[15] || (map == 4'd0);
    cur_ptr = ptr; done = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i * 3);
      dat_q.push_back(b);
      if (!drain) exp_d.push_back({map, b});
    end
    if (len == 0 || drain) exp_drop++;
    else begin
      exp_frame++;
      exp_p.push_back({map, 16'(len)});
    end
    ptr_q.push_back(ptr);
    seed += 37;
  endtask

  task automatic finish_frame(input string nm, input bit lat);
    int len, n; bit drain;
    len = int'(cur_ptr[10:0]); drain = cur_ptr[15] || (cur_ptr[14:11] == 4'd0);
    n = 0;
    while (!done && n < 4000) begin @(posedge clk); n++; end
    #1;
    chk({nm, " completed"}, 32'(done), 32'd1);
    chk({nm, " sfifo reads"}, 32'(n_rd), 32'(len));
    chk({nm, " data writes"}, 32'(n_wr), drain ? 32'd0 : 32'(len));
    if (lat) begin
      if (len == 0) chk({nm, " idle lat"}, 32'(t_idle - t0), 32'd2);
      else begin
        chk({nm, " first rd lat"}, 32'(t_first - t0), 32'd2);
        chk({nm, " idle lat"}, 32'(t_idle - t0), 32'(len + 4));
        if (!drain) begin
          chk({nm, " last wr lat"}, 32'(t_lastwr - t0), 32'(len + 2));
          chk({nm, " ptr wr lat"}, 32'(t_pw - t0), 32'(len + 3));
        end
      end
    end
    chk({nm, " frame_cnt"}, 32'(frame_cnt), STATS ? 32'(16'(exp_frame)) : 32'd0);
    chk({nm, " drop_cnt"}, 32'(drop_cnt), STATS ? 32'(16'(exp_drop)) : 32'd0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, " ptr_sfifo_rd"}, 32'(bus.ptr_sfifo_rd), 32'd0);
    chk({nm, " sfifo_rd"}, 32'(bus.sfifo_rd), 32'd0);
    chk({nm, " data wr"}, 32'(bus.tx_data_fifo_wr), 32'd0);
    chk({nm, " data din"}, 32'(bus.tx_data_fifo_din), 32'd0);
    chk({nm, " ptr wr"}, 32'(bus.tx_ptr_fifo_wr), 32'd0);
    chk({nm, " ptr din"}, 32'(bus.tx_ptr_fifo_din), 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " counters"}, {frame_cnt, drop_cnt}, 32'd0);
  endtask

  initial begin
    int k;
    bus.tx_data_fifo_afull = '0;
    bus.tx_ptr_fifo_full   = '0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Unicast to port1, 64 bytes
    start_frame(16'h1040); finish_frame("uni64", 1'b1);
    chk("uni64 port1 bytes", 32'(port_cnt[1]), 32'd64);
    chk("uni64 ptr wr lit", 32'(last_pwr), 32'b0010);
    chk("uni64 ptr din lit", 32'(last_pdin), 32'h0040);
    chk("uni64 ptr wr cycle", 32'(t_pw - t0), 32'd67);

    // Broadcast 60 bytes; backpressure raised mid-DATA must not stall
    start_frame(16'h783C);
    repeat (8) @(negedge clk);
    bus.tx_data_fifo_afull = 4'hF;
    finish_frame("bcast60", 1'b1);
    bus.tx_data_fifo_afull = '0;
    chk("bcast60 port3 bytes", 32'(port_cnt[3]), 32'd60);
    chk("bcast60 port1 bytes", 32'(port_cnt[1]), 32'd124);
    chk("bcast60 ptr wr lit", 32'(last_pwr), 32'b1111);

    // Error frame drained, then a normal frame must stay byte-aligned
    @(negedge clk);
    start_frame(16'h9040); finish_frame("err64", 1'b1);
    @(negedge clk);
    start_frame(16'h1010); finish_frame("after_err", 1'b1);
    @(negedge clk);
    start_frame(16'h0005); finish_frame("nomap5", 1'b1);
    @(negedge clk);
    start_frame(16'h0800); finish_frame("len0", 1'b1);

    // Masked port almost full holds the frame in WAIT
    @(negedge clk);
    bus.tx_data_fifo_afull = 4'b0100;
    start_frame(16'h2010);
    repeat (20) begin @(negedge clk); chk("wait afull sfifo_rd", 32'(bus.sfifo_rd), 32'd0); end
    chk("wait afull busy", 32'(busy), 32'd1);
    bus.tx_data_fifo_afull = '0;
    finish_frame("afull_wait", 1'b0);

    // Unmasked port almost full is ignored
    @(negedge clk);
    bus.tx_data_fifo_afull = 4'b0001;
    start_frame(16'h2010); finish_frame("afull_other", 1'b1);
    bus.tx_data_fifo_afull = '0;

    // Full ptr FIFO on one broadcast port stalls the whole frame
    @(negedge clk);
    bus.tx_ptr_fifo_full = 4'b1000;
    start_frame(16'h780A);
    repeat (10) begin @(negedge clk); chk("wait full sfifo_rd", 32'(bus.sfifo_rd), 32'd0); end
    bus.tx_ptr_fifo_full = '0;
    finish_frame("full_wait", 1'b0);

    // Reset in the middle of a 100-byte frame
    @(negedge clk);
    start_frame(16'h0864);
    k = 0;
    while (n_rd < 30 && k < 500) begin @(posedge clk); k++; end
    chk("midframe reached byte 30", 32'(n_rd >= 30), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_outputs_zero("midframe reset");
    ptr_q.delete(); dat_q.delete(); exp_d.delete(); exp_p.delete();
    exp_frame = 0; exp_drop = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_frame(16'h1820); finish_frame("post_reset", 1'b1);

    chk("scoreboard data drained", 32'(exp_d.size()), 32'd0);
    chk("scoreboard ptr drained", 32'(exp_p.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
